// File: rtl/redstone_pkg.sv
// Shared types for the redstone tick path: sequencer states and host command encodings.
package redstone_pkg;

  localparam int CMD_W   = 2;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } tick_state_e;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP   = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_PAUSE = 2'd2,
    CMD_STEP  = 2'd3
  } tick_cmd_e;

endpackage

// File: rtl/tick_sequencer.sv
// Turns divider tick edges into req/done tick requests for the simulation core,
// with run/pause/step control, a small pending buffer and overrun detection.
//
// state | meaning
// IDLE  | divider disabled, edges ignored, nothing new issued
// RUN   | every divider edge becomes a tick request
// STEP  | edges accepted until the loaded step count is used up
module tick_sequencer
  import redstone_pkg::*;
#(
  parameter int TICK_CNT_W = 32,
  parameter int PEND_W     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tick_clk,
  output logic                  o_div_en,
  input  logic                  i_cmd_valid,
  input  logic [CMD_W-1:0]      i_cmd,
  input  logic [TICK_CNT_W-1:0] i_step_count,
  output logic                  o_tick_req,
  input  logic                  i_tick_done,
  output logic [TICK_CNT_W-1:0] o_tick_count,
  output logic [PEND_W-1:0]     o_pending,
  output logic [STATE_W-1:0]    o_state,
  output logic                  o_step_done,
  output logic                  o_overrun,
  input  logic                  i_overrun_clr
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  tick_state_e           r_state;
  tick_state_e           w_state_nxt;
  tick_cmd_e             w_cmd;
  logic                  r_tick_d;
  logic [PEND_W-1:0]     r_pending;
  logic [PEND_W-1:0]     w_pending_nxt;
  logic [TICK_CNT_W-1:0] r_remaining;
  logic [TICK_CNT_W-1:0] w_remaining_nxt;
  logic                  r_in_flight;
  logic [TICK_CNT_W-1:0] r_tick_count;
  logic                  r_step_done;
  logic                  r_overrun;

  logic w_edge;
  logic w_accept_ok;
  logic w_can_issue;
  logic w_issue;
  logic w_accept;
  logic w_drop;
  logic w_flush;
  logic w_step_fin;
  logic w_complete;

  always_comb begin
    w_cmd           = tick_cmd_e'(i_cmd);
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_flush         = 1'b0;
    w_step_fin      = 1'b0;

    w_edge      = i_tick_clk & ~r_tick_d;
    w_accept_ok = (r_state == ST_RUN) || ((r_state == ST_STEP) && (r_remaining != '0));
    w_can_issue = !r_in_flight && (r_pending != '0);
    // A full buffer still takes the edge when an issue frees a slot in the same cycle.
    w_accept    = w_edge && w_accept_ok && ((r_pending != PEND_MAX) || w_can_issue);
    w_drop      = w_edge && w_accept_ok && (r_pending == PEND_MAX) && !w_can_issue;
    w_complete  = i_tick_done && r_in_flight;

    if (w_accept && (r_state == ST_STEP)) begin
      w_remaining_nxt = r_remaining - TICK_CNT_W'(1);
    end

    if (i_cmd_valid && (w_cmd != CMD_NOP)) begin
      case (w_cmd)
        CMD_RUN: begin
          w_state_nxt     = ST_RUN;
          w_remaining_nxt = '0;
        end
        CMD_PAUSE: begin
          w_state_nxt     = ST_IDLE;
          w_remaining_nxt = '0;
          w_flush         = 1'b1;
        end
        CMD_STEP: begin
          if (i_step_count == '0) begin
            w_state_nxt     = ST_IDLE;
            w_remaining_nxt = '0;
            w_flush         = 1'b1;
            w_step_fin      = 1'b1;
          end else begin
            w_state_nxt     = ST_STEP;
            w_remaining_nxt = i_step_count;
          end
        end
        default: ;
      endcase
    end else if ((r_state == ST_STEP) && (r_remaining == '0) && (r_pending == '0) && !r_in_flight) begin
      w_state_nxt = ST_IDLE;
      w_step_fin  = 1'b1;
    end

    w_issue = w_can_issue && !w_flush;

    if (w_flush) begin
      w_pending_nxt = '0;
    end else begin
      case ({w_accept, w_issue})
        2'b10:   w_pending_nxt = r_pending + PEND_W'(1);
        2'b01:   w_pending_nxt = r_pending - PEND_W'(1);
        default: w_pending_nxt = r_pending;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_tick_d     <= 1'b0;
      r_pending    <= '0;
      r_remaining  <= '0;
      r_in_flight  <= 1'b0;
      r_tick_count <= '0;
      r_step_done  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_d    <= i_tick_clk;
      r_pending   <= w_pending_nxt;
      r_remaining <= w_remaining_nxt;
      r_step_done <= w_step_fin;
      if (w_issue) begin
        r_in_flight <= 1'b1;
      end else if (w_complete) begin
        r_in_flight <= 1'b0;
      end
      if (w_complete) begin
        r_tick_count <= r_tick_count + TICK_CNT_W'(1);
      end
      if (i_overrun_clr) begin
        r_overrun <= 1'b0;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_div_en     = (r_state != ST_IDLE);
  assign o_tick_req   = r_in_flight;
  assign o_tick_count = r_tick_count;
  assign o_pending    = r_pending;
  assign o_state      = r_state;
  assign o_step_done  = r_step_done;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_tick_sequencer.sv
// Scoreboard bench for tick_sequencer: expected tick counts at each request are queued
// by the stimulus and checked by a monitor when o_tick_req rises.
module tb_tick_sequencer;
  import redstone_pkg::*;

  localparam int TW = 32;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_clk = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd = 2'd0;
  logic [TW-1:0] step_count = '0;
  logic          auto_done = 1'b0;
  logic          man_done = 1'b0;
  logic          tick_done;
  logic          overrun_clr = 1'b0;
  logic          hold = 1'b0;

  logic          div_en;
  logic          tick_req;
  logic [TW-1:0] tick_count;
  logic [PW-1:0] pending;
  logic [1:0]    state;
  logic          step_done;
  logic          overrun;

  int checks = 0;
  int failures = 0;
  int step_pulses = 0;
  int base;
  int exp_q[$];
  logic req_prev = 1'b0;

  assign tick_done = auto_done | man_done;

  tick_sequencer #(.TICK_CNT_W(TW), .PEND_W(PW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_tick_clk   (tick_clk),
    .o_div_en     (div_en),
    .i_cmd_valid  (cmd_valid),
    .i_cmd        (cmd),
    .i_step_count (step_count),
    .o_tick_req   (tick_req),
    .i_tick_done  (tick_done),
    .o_tick_count (tick_count),
    .o_pending    (pending),
    .o_state      (state),
    .o_step_done  (step_done),
    .o_overrun    (overrun),
    .i_overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every new request must match the next queued tick count.
  initial begin
    forever begin
      @(negedge clk);
      if (tick_req && !req_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req: got req at count %0d expected none", tick_count);
        end else begin
          chk("req_count", longint'(tick_count), longint'(exp_q.pop_front()));
        end
      end
      req_prev = tick_req;
      if (step_done) step_pulses++;
    end
  end

  // Core model: answers done three cycles after a request unless held.
  initial begin
    int lat;
    lat = 0;
    forever begin
      @(negedge clk);
      auto_done = 1'b0;
      if (tick_req && !hold) begin
        lat++;
        if (lat == 3) begin
          auto_done = 1'b1;
          lat = 0;
        end
      end else begin
        lat = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [1:0] c, input logic [TW-1:0] n);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = c;
    step_count = n;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = 2'd0;
  endtask

  task automatic edge_t(input int low);
    @(negedge clk) tick_clk = 1'b1;
    @(negedge clk) tick_clk = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  initial begin
    cycles(3);
    chk("rst_state", state, 0);
    chk("rst_div_en", div_en, 0);
    chk("rst_req", tick_req, 0);
    chk("rst_count", tick_count, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_step_done", step_done, 0);
    rst_n = 1'b1;

    // Run, core answers after 3 cycles, five edges
    send(CMD_RUN, '0);
    chk("run_state", state, 1);
    chk("run_div_en", div_en, 1);
    @(negedge clk) tick_clk = 1'b1;
    exp_q.push_back(0);
    @(negedge clk);
    chk("lat_n1_req", tick_req, 0);
    chk("lat_n1_pending", pending, 1);
    tick_clk = 1'b0;
    @(negedge clk);
    chk("lat_n2_req", tick_req, 1);
    cycles(10);
    for (int i = 1; i < 5; i++) begin
      exp_q.push_back(i);
      edge_t(10);
    end
    cycles(10);
    chk("run_count", tick_count, 5);
    chk("run_overrun", overrun, 0);
    chk("run_pending", pending, 0);

    // Core stalls: buffer saturates, fifth edge overruns
    hold = 1'b1;
    exp_q.push_back(5);
    edge_t(3);
    edge_t(3);
    edge_t(3);
    edge_t(3);
    chk("sat_pending", pending, 3);
    chk("sat_no_overrun", overrun, 0);
    edge_t(3);
    chk("ovr_flag", overrun, 1);
    chk("ovr_pending", pending, 3);
    exp_q.push_back(6);
    exp_q.push_back(7);
    exp_q.push_back(8);
    hold = 1'b0;
    cycles(40);
    chk("ovr_count", tick_count, 9);
    chk("ovr_sticky", overrun, 1);
    @(negedge clk) overrun_clr = 1'b1;
    @(negedge clk) overrun_clr = 1'b0;
    chk("ovr_cleared", overrun, 0);

    // Step 4 from idle
    send(CMD_PAUSE, '0);
    chk("pause_state", state, 0);
    chk("pause_div_en", div_en, 0);
    base = step_pulses;
    send(CMD_STEP, 32'd4);
    chk("step_state", state, 2);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(9 + i);
      edge_t(12);
    end
    cycles(6);
    chk("step_done_pulses", step_pulses - base, 1);
    chk("step_end_state", state, 0);
    chk("step_end_div_en", div_en, 0);
    chk("step_count", tick_count, 13);
    edge_t(5);
    edge_t(5);
    chk("idle_ign_count", tick_count, 13);
    chk("idle_ign_pending", pending, 0);

    // Pause with one in flight and two pending
    hold = 1'b1;
    send(CMD_RUN, '0);
    exp_q.push_back(13);
    edge_t(3);
    edge_t(3);
    edge_t(3);
    chk("pp_pending", pending, 2);
    chk("pp_req", tick_req, 1);
    send(CMD_PAUSE, '0);
    chk("pp_state", state, 0);
    chk("pp_flushed", pending, 0);
    chk("pp_req_held", tick_req, 1);
    hold = 1'b0;
    cycles(10);
    chk("pp_count", tick_count, 14);
    chk("pp_no_req", tick_req, 0);

    // Edge coincident with issue at full buffer
    hold = 1'b1;
    send(CMD_RUN, '0);
    exp_q.push_back(14);
    edge_t(3);
    edge_t(3);
    edge_t(3);
    edge_t(3);
    chk("co_pre_pending", pending, 3);
    @(negedge clk) man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    tick_clk = 1'b1;
    exp_q.push_back(15);
    @(negedge clk) tick_clk = 1'b0;
    chk("co_pending", pending, 3);
    chk("co_overrun", overrun, 0);
    chk("co_req", tick_req, 1);

    // Step of zero from run
    base = step_pulses;
    send(CMD_STEP, '0);
    chk("s0_state", state, 0);
    chk("s0_div_en", div_en, 0);
    cycles(2);
    chk("s0_pulses", step_pulses - base, 1);
    chk("s0_count", tick_count, 15);
    @(negedge clk) man_done = 1'b1;
    @(negedge clk) man_done = 1'b0;
    chk("s0_final_count", tick_count, 16);
    cycles(3);
    chk("s0_no_req", tick_req, 0);

    // Asynchronous reset mid-step with a request outstanding
    send(CMD_STEP, 32'd2);
    exp_q.push_back(16);
    edge_t(3);
    chk("rm_req", tick_req, 1);
    chk("rm_state", state, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_req_clr", tick_req, 0);
    chk("rm_state_clr", state, 0);
    chk("rm_count_clr", tick_count, 0);
    chk("rm_div_en_clr", div_en, 0);
    chk("rm_pending_clr", pending, 0);
    chk("rm_step_done_clr", step_done, 0);
    @(negedge clk) rst_n = 1'b1;
    hold = 1'b0;
    cycles(5);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_sequencer.md
Name: tick_sequencer

Overview:
- Sits directly downstream of the TPS phase-accumulator clock divider.
- Consumes the divider's tick-rate square wave and turns each rising edge into one tick request to the redstone simulation core, using a req/done handshake.
- Implements host run, pause and step control, and buffers a small number of tick edges that arrive while the core is busy.
- Counts completed ticks and flags overruns: tick edges lost because the buffer was full.

Parameters:
- TICK_CNT_W, 32, width of completed-tick counter and step-count load value.
- PEND_W, 2, width of pending-tick counter; maximum pending = 2^PEND_W-1 (default 3).

Ports:
- i_clk  in  1  system clock; divider and simulation core share this domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tick_clk  in  1  divider tick output, synchronous to i_clk.
- o_div_en  out  1  enable to divider; high whenever state != IDLE.
- i_cmd_valid  in  1  one-cycle command strobe; always accepted.
- i_cmd  in  2  00 NOP, 01 RUN, 10 PAUSE, 11 STEP.
- i_step_count  in  TICK_CNT_W  number of ticks for STEP, sampled with i_cmd_valid.
- o_tick_req  out  1  level; high while one tick is in flight in the core.
- i_tick_done  in  1  one-cycle pulse from core; completes the in-flight tick.
- o_tick_count  out  TICK_CNT_W  completed ticks since reset; wraps.
- o_pending  out  PEND_W  accepted edges not yet issued.
- o_state  out  2  IDLE=0, RUN=1, STEP=2.
- o_step_done  out  1  one-cycle pulse when a STEP sequence fully completes.
- o_overrun  out  1  sticky overrun flag.
- i_overrun_clr  in  1  clears o_overrun.

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears all state:
  - state=IDLE; o_div_en, o_tick_req, o_step_done, o_overrun = 0.
  - o_pending=0, o_tick_count=0, step remaining=0, edge-detect register=0.
- Edge detect:
  - edge = i_tick_clk & ~r_tick_d, where r_tick_d is i_tick_clk registered.
  - Edges are accepted only in RUN, or in STEP with remaining > 0; edges in IDLE are ignored.
- Accept:
  - If pending < max, pending increments, visible the cycle after the edge.
  - In STEP, an accepted edge also decrements remaining.
  - If pending == max and no issue occurs in the same cycle, the edge is dropped and o_overrun is set; it is not counted against remaining.
- Issue: when in_flight=0 and pending>0, set in_flight (o_tick_req=1 next cycle) and decrement pending.
  - Edge accept and issue in the same cycle: net pending change is 0, with no overrun.
  - Latency: i_tick_clk first sampled high in cycle N gives o_tick_req high in cycle N+2 when the core is idle and pending=0.
- Complete: i_tick_done while in_flight clears in_flight next cycle and increments o_tick_count (wraps to 0).
  - i_tick_done while !in_flight is ignored.
  - An issue may happen in the cycle after completion; there is no back-to-back issue in the done cycle.
- FSM:
  - IDLE -RUN-> RUN.
  - IDLE -STEP n>0-> STEP with remaining=n.
  - STEP n=0 from any state: go to IDLE, then pulse o_step_done next cycle.
  - RUN -STEP n-> STEP with remaining reloaded; pending is kept.
  - STEP -RUN-> RUN; remaining is cleared.
  - Any -PAUSE-> IDLE: pending is discarded (set to 0). A tick already in flight still completes and counts.
  - STEP -> IDLE automatically when remaining==0, pending==0 and in_flight==0; o_step_done pulses in the transition cycle+1.
  - NOP has no effect.
- Overrun clear:
  - o_overrun: i_overrun_clr has priority over a same-cycle set.
- Reset mid-tick: in_flight clears immediately. The core must also be reset from the same i_rst_n.

Decomposition:
- redstone_pkg holds:
  - tick_state_e (IDLE/RUN/STEP).
  - tick_cmd_e (NOP/RUN/PAUSE/STEP).
  - CMD_W=2 and STATE_W=2 localparams.
- No sub-module: the edge detector, pending counter and FSM stay in one module.

Test Plan:
- RUN; core answers done 3 cycles after req; 5 divider edges -> o_tick_req pulses 5 times, o_tick_count=5, o_overrun=0, first req 2 cycles after first i_tick_clk high.
- RUN; core withholds done; 5 edges -> o_pending saturates at 3 after edge 4, o_overrun=1 on edge 5; release done -> count reaches 4; i_overrun_clr -> o_overrun=0.
- STEP n=4 from IDLE -> exactly 4 reqs and o_tick_count=4; o_step_done pulses once; state returns to IDLE; o_div_en drops; further edges are ignored.
- PAUSE while in_flight=1 and pending=2 -> state IDLE, pending=0, in-flight tick completes (count +1), no new req.
- Edge accept coincident with issue at pending=3 -> pending stays 3, no overrun; STEP n=0 -> immediate IDLE, o_step_done pulse, count unchanged.
- Assert i_rst_n low mid-STEP with req high -> all outputs 0 asynchronously, o_tick_count=0.
